cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result-broadcast arbiter that sits directly upstream of the register bank and the reservation stations. It buffers completed results from the two ALUs in small per-ALU queues. Each cycle it grants at most one queued result round-robin and drives it as a registered 16-bit common data bus (CDB) word. CDB write-enable bits are forced to zero on idle cycles, so downstream registers never see a spurious write.

## Interface
- DEPTH, 2, entries per ALU queue; power of two, ≥2
- DATA_W, 10, result data width; fixed at 10 by the CDB format
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- alu0_valid  in  1  ALU0 offers a result this cycle
- alu0_ready  out  1  ALU0 queue can accept; a transfer occurs on an edge where valid && ready
- alu0_dest  in  3  one-hot destination: [2]=R0, [1]=R1, [0]=R2; 000 means no register write
- alu0_rs_pos  in  2  reservation-station slot of the producing instruction
- alu0_data  in  10  result value
- alu1_valid, alu1_ready, alu1_dest, alu1_rs_pos, alu1_data: same as ALU0, for ALU1
- cdb  out  16  [15]=R0 wren, [14]=R1 wren, [13]=R2 wren, [12:11]=rs_pos, [10]=ALU id (0=ALU0, 1=ALU1), [9:0]=data
- cdb_valid  out  1  cdb carries a broadcast this cycle

## Operation
- Two independent circular FIFOs of DEPTH entries, each 15 bits wide (dest, rs_pos, data). Each has a write pointer, a read pointer, and a count from 0 to DEPTH.
  - Pointers wrap modulo DEPTH.
  - Count width is log2(DEPTH)+1.
- Push: on an edge with aluN_valid && aluN_ready, the entry is written at the write pointer, and the write pointer advances.
- aluN_ready = reset && (countN < DEPTH). It is combinational from registered count. There is no same-cycle bypass, so a full queue deasserts ready even if it pops that cycle.
- Arbitration is combinational on the current counts and selects at most one non-empty queue per cycle:
  - If only one queue is non-empty, that queue is selected.
  - If both are non-empty, the queue not granted last is selected. The last_grant register records the ALU id of the most recent grant.
  - Neither non-empty: no grant, and last_grant holds.
- Grant: on the edge, the head entry of the selected queue is popped and registered into cdb, with cdb[10] = selected id, and cdb_valid=1.
- No grant: on the edge, cdb <= 16'h0000 and cdb_valid <= 0.
- A push and a pop may hit the same queue on the same edge; the count is then unchanged.
- Per-ALU ordering is strictly FIFO. Cross-ALU ordering follows arbitration only.
- dest is passed through unmodified, including 000 (slot-release-only broadcast with cdb_valid=1) and multi-hot values; the arbiter does not check dest.
- Inputs are ignored when valid=0 or ready=0; the data lines are don't-care then.

## Timing
- Reset asserted (asynchronously): both queues are emptied and pointers and counts are zeroed.
  - last_grant=1, so ALU0 wins the first tie.
  - cdb=16'h0000 and cdb_valid=0 immediately, without waiting for a clock edge.
  - alu0_ready=alu1_ready=0 while reset=0.
- Reset released: ready=1 in the same cycle. The first push is accepted on the next edge.
- Latency: a result pushed into an empty, uncontested queue at edge N appears on cdb after edge N+1 and is held for exactly one cycle.
- Contention: both queues non-empty → grants alternate every cycle. Maximum wait for any head entry is 1 extra cycle.
- Throughput: 1 broadcast per cycle total. Sustained dual-ALU input of 2 per cycle fills the queues, and ready then throttles each ALU to about 1 push every 2 cycles.
- Reset during operation discards all queued entries. No partial or stale word is ever broadcast after release.

## Test plan
- Reset: hold reset=0 with alu0_valid=1 → cdb=16'h0000, cdb_valid=0, both ready=0; drop reset mid-cycle → outputs clear with no clock edge.
- Single result: ALU0 push dest=100, rs_pos=2, data=37 at edge 1 → after edge 2, cdb=16'h9025 and cdb_valid=1; after edge 3, cdb=16'h0000 and cdb_valid=0.
- Tie after reset: both ALUs push at the same edge, ALU0 (dest=010, rs=0, data=5) and ALU1 (dest=001, rs=1, data=9) → next cycle cdb=16'h4005, following cycle cdb=16'h2C09, then idle.
- Backpressure with DEPTH=2: both ALUs hold valid=1 with incrementing data for 12 cycles → ready drops at full and broadcasts alternate ALU0/ALU1. Every accepted value appears exactly once, in per-ALU order, with none lost or duplicated.
- Zero-dest: ALU1 push dest=000, rs=3, data=1023 → cdb=16'h1FFF with cdb_valid=1 and cdb[15:13]=000.
- Reset mid-operation: fill both queues, assert reset for 1 cycle, release → no broadcast of old entries and counts are 0. A new ALU1 push then appears with 1-cycle latency.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two per-ALU result FIFOs drained round-robin onto a
// registered 16-bit broadcast word; idle cycles drive an all-zero word.
module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu0_valid,
    output logic              alu0_ready,
    input  logic [2:0]        alu0_dest,
    input  logic [1:0]        alu0_rs_pos,
    input  logic [DATA_W-1:0] alu0_data,
    input  logic              alu1_valid,
    output logic              alu1_ready,
    input  logic [2:0]        alu1_dest,
    input  logic [1:0]        alu1_rs_pos,
    input  logic [DATA_W-1:0] alu1_data,
    output logic [15:0]       cdb,
    output logic              cdb_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]        dest;
        logic [1:0]        rs_pos;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_q    [2][DEPTH];
    entry_t           in_entry [2];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];
    logic             last_grant_q, last_grant_d;
    logic [15:0]      cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;

    logic [1:0] in_valid;
    logic [1:0] ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] nonempty;
    logic       grant;
    logic       sel;

    assign in_valid    = {alu1_valid, alu0_valid};
    assign in_entry[0] = {alu0_dest, alu0_rs_pos, alu0_data};
    assign in_entry[1] = {alu1_dest, alu1_rs_pos, alu1_data};

    // Ready looks only at the registered count, so a full queue stays
    // not-ready even on the cycle it is being popped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nonempty = '0;
        ready    = '0;
        push     = '0;
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            ready[i]    = reset && (cnt_q[i] < CNT_W'(DEPTH));
            push[i]     = in_valid[i] && ready[i];
        end
    end

    // On a tie the queue not granted last wins; otherwise the lone non-empty one.
    always_comb begin
        grant = |nonempty;
        sel   = (&nonempty) ? ~last_grant_q : nonempty[1];
        pop   = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
        head  = mem_q[sel][rd_ptr_q[sel]];
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        last_grant_d = grant ? sel : last_grant_q;
        cdb_d        = grant ? {head.dest, head.rs_pos, sel, head.data} : 16'h0000;
        cdb_valid_d  = grant;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            last_grant_q <= 1'b1;
            cdb_q        <= 16'h0000;
            cdb_valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            last_grant_q <= last_grant_d;
            cdb_q        <= cdb_d;
            cdb_valid_q  <= cdb_valid_d;
        end
    end

    // NOTE: queue storage is not reset; zeroed counts make stale entries unreachable.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_entry[i];
            end
        end
    end

    assign alu0_ready = ready[0];
    assign alu1_ready = ready[1];
    assign cdb        = cdb_q;
    assign cdb_valid  = cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (DEPTH=2): reset behaviour,
// latency, tie-break, zero-dest, backpressure ordering and mid-run reset.
module tb_cdb_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       alu0_valid, alu1_valid;
    logic       alu0_ready, alu1_ready;
    logic [2:0] alu0_dest, alu1_dest;
    logic [1:0] alu0_rs_pos, alu1_rs_pos;
    logic [9:0] alu0_data, alu1_data;
    logic [15:0] cdb;
    logic        cdb_valid;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(.DEPTH(2), .DATA_W(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu0_valid  (alu0_valid),
        .alu0_ready  (alu0_ready),
        .alu0_dest   (alu0_dest),
        .alu0_rs_pos (alu0_rs_pos),
        .alu0_data   (alu0_data),
        .alu1_valid  (alu1_valid),
        .alu1_ready  (alu1_ready),
        .alu1_dest   (alu1_dest),
        .alu1_rs_pos (alu1_rs_pos),
        .alu1_data   (alu1_data),
        .cdb         (cdb),
        .cdb_valid   (cdb_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Backpressure trace, hand-derived: queues start empty with last grant = ALU1.
    // Ready pairs are {alu1_ready, alu0_ready} before edges 1..12.
    logic [1:0] bp_ready [12] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10,
                                  2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    int bp_id  [16] = '{-1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, -1};
    int bp_val [16] = '{0, 'h10, 'h20, 'h11, 'h21, 'h12, 'h22, 'h13,
                        'h23, 'h14, 'h24, 'h15, 'h25, 'h16, 'h26, 0};

    initial begin
        logic [15:0] exp_word;
        logic [9:0]  d0, d1;
        logic        acc0, acc1;

        reset       = 1'b0;
        alu0_valid  = 1'b1;
        alu0_dest   = 3'b111;
        alu0_rs_pos = 2'd3;
        alu0_data   = 10'h3FF;
        alu1_valid  = 1'b0;
        alu1_dest   = 3'b000;
        alu1_rs_pos = 2'd0;
        alu1_data   = 10'h000;

        // Reset held across several edges with a valid offer present
        repeat (3) @(posedge clock);
        #1;
        check("rst_cdb", cdb, 16'h0000);
        check("rst_cdb_valid", {15'b0, cdb_valid}, 16'h0000);
        check("rst_ready0", {15'b0, alu0_ready}, 16'h0000);
        check("rst_ready1", {15'b0, alu1_ready}, 16'h0000);

        alu0_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check("rel_ready0", {15'b0, alu0_ready}, 16'h0001);
        check("rel_ready1", {15'b0, alu1_ready}, 16'h0001);

        // Single result: one-cycle latency, held one cycle
        alu0_dest = 3'b100; alu0_rs_pos = 2'd2; alu0_data = 10'd37; alu0_valid = 1'b1;
        tick();
        alu0_valid = 1'b0;
        check("single_lat0_valid", {15'b0, cdb_valid}, 16'h0000);
        tick();
        check("single_cdb", cdb, 16'h9025);
        check("single_valid", {15'b0, cdb_valid}, 16'h0001);
        tick();
        check("single_idle_cdb", cdb, 16'h0000);
        check("single_idle_valid", {15'b0, cdb_valid}, 16'h0000);

        // Tie right after a fresh reset: ALU0 wins first
        reset = 1'b0;
        #2;
        reset = 1'b1;
        alu0_dest = 3'b010; alu0_rs_pos = 2'd0; alu0_data = 10'd5; alu0_valid = 1'b1;
        alu1_dest = 3'b001; alu1_rs_pos = 2'd1; alu1_data = 10'd9; alu1_valid = 1'b1;
        tick();
        alu0_valid = 1'b0;
        alu1_valid = 1'b0;
        tick();
        check("tie_first", cdb, 16'h4005);
        tick();
        check("tie_second", cdb, 16'h2C09);
        check("tie_second_valid", {15'b0, cdb_valid}, 16'h0001);
        tick();
        check("tie_idle", cdb, 16'h0000);
        check("tie_idle_valid", {15'b0, cdb_valid}, 16'h0000);

        // Zero destination still broadcasts
        alu1_dest = 3'b000; alu1_rs_pos = 2'd3; alu1_data = 10'd1023; alu1_valid = 1'b1;
        tick();
        alu1_valid = 1'b0;
        tick();
        check("zdest_cdb", cdb, 16'h1FFF);
        check("zdest_valid", {15'b0, cdb_valid}, 16'h0001);
        check("zdest_wren", {13'b0, cdb[15:13]}, 16'h0000);
        tick();

        // Sustained dual input for 12 edges, then drain
        d0 = 10'h010;
        d1 = 10'h020;
        alu0_dest = 3'b100; alu0_rs_pos = 2'd1; alu0_data = d0; alu0_valid = 1'b1;
        alu1_dest = 3'b010; alu1_rs_pos = 2'd2; alu1_data = d1; alu1_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k < 12) begin
                check($sformatf("bp%0d_ready", k + 1), {14'b0, alu1_ready, alu0_ready},
                      {14'b0, bp_ready[k]});
            end
            acc0 = alu0_valid && alu0_ready;
            acc1 = alu1_valid && alu1_ready;
            tick();
            if (acc0) d0 = d0 + 10'd1;
            if (acc1) d1 = d1 + 10'd1;
            alu0_data = d0;
            alu1_data = d1;
            if (k == 11) begin
                alu0_valid = 1'b0;
                alu1_valid = 1'b0;
            end
            if (bp_id[k] < 0)
                exp_word = 16'h0000;
            else if (bp_id[k] == 0)
                exp_word = {3'b100, 2'd1, 1'b0, 10'(bp_val[k])};
            else
                exp_word = {3'b010, 2'd2, 1'b1, 10'(bp_val[k])};
            check($sformatf("bp%0d_cdb", k + 1), cdb, exp_word);
            check($sformatf("bp%0d_valid", k + 1), {15'b0, cdb_valid},
                  {15'b0, (bp_id[k] >= 0)});
        end

        // Reset mid-operation discards queued entries
        alu0_dest = 3'b111; alu0_rs_pos = 2'd3; alu0_data = 10'h0AA; alu0_valid = 1'b1;
        alu1_dest = 3'b011; alu1_rs_pos = 2'd0; alu1_data = 10'h0BB; alu1_valid = 1'b1;
        tick();
        tick();
        alu0_valid = 1'b0;
        alu1_valid = 1'b0;
        check("mid_pre_cdb", cdb, 16'hF8AA);
        reset = 1'b0;
        #1;
        check("mid_async_cdb", cdb, 16'h0000);
        check("mid_async_valid", {15'b0, cdb_valid}, 16'h0000);
        check("mid_async_ready0", {15'b0, alu0_ready}, 16'h0000);
        check("mid_async_ready1", {15'b0, alu1_ready}, 16'h0000);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rel_ready0", {15'b0, alu0_ready}, 16'h0001);
        check("mid_rel_ready1", {15'b0, alu1_ready}, 16'h0001);
        tick();
        check("mid_flush1_valid", {15'b0, cdb_valid}, 16'h0000);
        check("mid_flush1_cdb", cdb, 16'h0000);
        tick();
        check("mid_flush2_valid", {15'b0, cdb_valid}, 16'h0000);

        alu1_dest = 3'b001; alu1_rs_pos = 2'd0; alu1_data = 10'h155; alu1_valid = 1'b1;
        tick();
        alu1_valid = 1'b0;
        check("post_lat0_valid", {15'b0, cdb_valid}, 16'h0000);
        tick();
        check("post_cdb", cdb, 16'h2555);
        check("post_valid", {15'b0, cdb_valid}, 16'h0001);
        tick();
        check("post_idle_cdb", cdb, 16'h0000);
        check("post_idle_valid", {15'b0, cdb_valid}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
